msx_sdram_arbiter: RTL and testbench

Arbitrates the single-port SDRAM between three requesters: the ROM/keyboard download writer, the CPU slot datapath (RAM, MSX2 mapper RAM, cartridge ROM) and the NVRAM backup copier. It sits between those blocks and the SDRAM controller and sequences one byte transaction at a time. Each transaction uses a req/ack handshake, with fixed priority plus a starvation guard for the backup channel. A watchdog keeps a hung SDRAM from locking the CPU.

---
 rtl/msx_sdram_arbiter.sv | 142 ++++++++++++++
 tb/tb_msx_sdram_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/msx_sdram_arbiter.sv
// SDRAM arbiter for the MSX core: serialises download, CPU slot and NVRAM backup
// byte accesses onto one SDRAM controller port, with a starvation guard and a watchdog.
module msx_sdram_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dw_req,
  input  logic [24:0] dw_addr,
  input  logic [7:0]  dw_din,
  output logic        dw_ack,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [24:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  input  logic        bk_req,
  input  logic        bk_we,
  input  logic [24:0] bk_addr,
  input  logic [7:0]  bk_din,
  output logic [7:0]  bk_dout,
  output logic        bk_ack,
  output logic [24:0] sdram_addr,
  output logic [7:0]  sdram_din,
  output logic        sdram_rd,
  output logic        sdram_we,
  input  logic        sdram_ready,
  input  logic [7:0]  sdram_dout,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);
  localparam logic [7:0] TMO  = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {OWN_DW, OWN_CPU, OWN_BK} owner_t;

  state_t     state, state_nxt;
  owner_t     owner;
  logic       we_l;
  logic [7:0] wd_cnt;
  logic [3:0] starve_cnt;
  logic       bk_force, gnt_dw, gnt_cpu, gnt_bk, wd_hit;
  logic [7:0] rd_val;

  // Backup is forced past the CPU once it has been starved long enough; download never yields.
  assign bk_force = (starve_cnt == SLIM) && bk_req;
  assign gnt_dw   = (state == IDLE) && dw_req;
  assign gnt_cpu  = (state == IDLE) && !dw_req && cpu_req && !bk_force;
  assign gnt_bk   = (state == IDLE) && !dw_req && bk_req && (!cpu_req || bk_force);
  assign wd_hit   = (wd_cnt == TMO);
  assign rd_val   = sdram_ready ? sdram_dout : 8'hFF;

  always_comb begin
    state_nxt = state;
    sdram_rd  = 1'b0;
    sdram_we  = 1'b0;
    dw_ack    = 1'b0;
    cpu_ack   = 1'b0;
    bk_ack    = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (gnt_dw || gnt_cpu || gnt_bk) state_nxt = ISSUE;
      ISSUE: begin
        sdram_rd  = !we_l;
        sdram_we  = we_l;
        state_nxt = WAIT;
      end
      WAIT:  if (sdram_ready || wd_hit) state_nxt = DONE;
      DONE: begin
        dw_ack    = (owner == OWN_DW);
        cpu_ack   = (owner == OWN_CPU);
        bk_ack    = (owner == OWN_BK);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner       <= OWN_DW;
      we_l        <= 1'b0;
      sdram_addr  <= '0;
      sdram_din   <= '0;
      cpu_dout    <= 8'hFF;
      bk_dout     <= 8'hFF;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_dw) begin
            owner      <= OWN_DW;
            we_l       <= 1'b1;
            sdram_addr <= dw_addr;
            sdram_din  <= dw_din;
          end else if (gnt_cpu) begin
            owner      <= OWN_CPU;
            we_l       <= cpu_we;
            sdram_addr <= cpu_addr;
            sdram_din  <= cpu_din;
          end else if (gnt_bk) begin
            owner      <= OWN_BK;
            we_l       <= bk_we;
            sdram_addr <= bk_addr;
            sdram_din  <= bk_din;
          end
        end
        // wd_cnt counts WAIT cycles including the current one, so the abort
        // lands TIMEOUT cycles into WAIT and the ack TIMEOUT+1 after the strobe.
        ISSUE: wd_cnt <= 8'd1;
        WAIT: begin
          wd_cnt <= wd_cnt + 8'd1;
          if (sdram_ready || wd_hit) begin
            if (!sdram_ready) timeout_err <= 1'b1;
            if (!we_l) begin
              if (owner == OWN_CPU) cpu_dout <= rd_val;
              if (owner == OWN_BK)  bk_dout  <= rd_val;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      starve_cnt <= '0;
    else if (!bk_req || gnt_bk)        starve_cnt <= '0;
    else if (gnt_cpu && starve_cnt < SLIM) starve_cnt <= starve_cnt + 4'd1;
  end

endmodule

// File: tb/tb_msx_sdram_arbiter.sv
// Scoreboard bench for msx_sdram_arbiter: stimulus pushes expected strobes/acks,
// a forked monitor pops and compares them as the DUT presents them.
module tb_msx_sdram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dw_req, dw_ack;
  logic [24:0] dw_addr;
  logic [7:0]  dw_din;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [24:0] cpu_addr;
  logic [7:0]  cpu_din, cpu_dout;
  logic        bk_req, bk_we, bk_ack;
  logic [24:0] bk_addr;
  logic [7:0]  bk_din, bk_dout;
  logic [24:0] sdram_addr;
  logic [7:0]  sdram_din, sdram_dout;
  logic        sdram_rd, sdram_we, sdram_ready;
  logic        busy, timeout_err;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  msx_sdram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .dw_req(dw_req), .dw_addr(dw_addr), .dw_din(dw_din), .dw_ack(dw_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .bk_req(bk_req), .bk_we(bk_we), .bk_addr(bk_addr), .bk_din(bk_din),
    .bk_dout(bk_dout), .bk_ack(bk_ack),
    .sdram_addr(sdram_addr), .sdram_din(sdram_din), .sdram_rd(sdram_rd),
    .sdram_we(sdram_we), .sdram_ready(sdram_ready), .sdram_dout(sdram_dout),
    .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {int ch; bit rd; logic [7:0] dout; int cyc;} ack_t;
  typedef struct {bit we; logic [24:0] addr; logic [7:0] din; int cyc;} stb_t;

  ack_t aq[$];
  stb_t sq[$];
  int   errors = 0;
  int   checks = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: never ready, 2: ready rdy_dly cycles after strobe
  int   rdy_dly  = 2;
  int   stb_cyc  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ack(input int ch, input bit rd, input logic [7:0] d, input int c);
    ack_t a;
    a.ch = ch; a.rd = rd; a.dout = d; a.cyc = c;
    aq.push_back(a);
  endtask

  task automatic push_stb(input bit we, input logic [24:0] addr, input logic [7:0] din, input int c);
    stb_t s;
    s.we = we; s.addr = addr; s.din = din; s.cyc = c;
    sq.push_back(s);
  endtask

  task automatic monitor();
    ack_t a;
    stb_t s;
    int   n, ch;
    forever begin
      @(negedge clk);
      if (sdram_rd || sdram_we) begin
        stb_cyc = cyc;
        if (sq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: rd=%0b we=%0b addr=%0h at cycle %0d", sdram_rd, sdram_we, sdram_addr, cyc);
        end else begin
          s = sq.pop_front();
          chk("strobe_we", {31'd0, sdram_we}, {31'd0, s.we});
          chk("strobe_rd", {31'd0, sdram_rd}, {31'd0, !s.we});
          chk("strobe_cycle", cyc, s.cyc);
          chk("strobe_addr", {7'd0, sdram_addr}, {7'd0, s.addr});
          if (s.we) chk("strobe_din", {24'd0, sdram_din}, {24'd0, s.din});
        end
      end
      n = int'(dw_ack) + int'(cpu_ack) + int'(bk_ack);
      if (n > 0) begin
        chk("single_ack", n, 1);
        ch = dw_ack ? 0 : (cpu_ack ? 1 : 2);
        if (aq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: channel %0d at cycle %0d", ch, cyc);
        end else begin
          a = aq.pop_front();
          chk("ack_channel", ch, a.ch);
          chk("ack_cycle", cyc, a.cyc);
          if (a.rd) chk("ack_dout", {24'd0, (ch == 1) ? cpu_dout : bk_dout}, {24'd0, a.dout});
        end
      end
      sdram_ready = (rdy_mode == 0) ? 1'b1 :
                    (rdy_mode == 1) ? 1'b0 : (cyc >= stb_cyc + rdy_dly);
    end
  endtask

  // Wait for the given number of acks per channel, dropping each req on its last ack.
  task automatic run(input int wdw, input int wcpu, input int wbk);
    int sdw = 0, scpu = 0, sbk = 0, n = 0;
    while ((sdw < wdw || scpu < wcpu || sbk < wbk) && n < 1000) begin
      @(negedge clk);
      n++;
      if (dw_ack)  begin sdw++;  if (sdw  >= wdw)  dw_req  = 1'b0; end
      if (cpu_ack) begin scpu++; if (scpu >= wcpu) cpu_req = 1'b0; end
      if (bk_ack)  begin sbk++;  if (sbk  >= wbk)  bk_req  = 1'b0; end
    end
    if (sdw < wdw || scpu < wcpu || sbk < wbk) begin
      checks++; errors++;
      $display("FAIL ack_wait_timeout: got dw=%0d cpu=%0d bk=%0d need %0d/%0d/%0d", sdw, scpu, sbk, wdw, wcpu, wbk);
      dw_req = 1'b0; cpu_req = 1'b0; bk_req = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_acks"},  {29'd0, dw_ack, cpu_ack, bk_ack}, 32'd0);
    chk({tag, "_strb"},  {30'd0, sdram_rd, sdram_we}, 32'd0);
    chk({tag, "_terr"},  {31'd0, timeout_err}, 32'd0);
    chk({tag, "_cdout"}, {24'd0, cpu_dout}, 32'hFF);
    chk({tag, "_bdout"}, {24'd0, bk_dout}, 32'hFF);
    chk({tag, "_saddr"}, {7'd0, sdram_addr}, 32'd0);
    chk({tag, "_sdin"},  {24'd0, sdram_din}, 32'd0);
  endtask

  initial begin
    int k;
    reset_n = 1'b0;
    dw_req = 0; dw_addr = '0; dw_din = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
    bk_req = 0; bk_we = 0; bk_addr = '0; bk_din = '0;
    sdram_ready = 1'b1; sdram_dout = 8'h00;
    fork monitor(); join_none

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // CPU read, ready two cycles after the strobe
    rdy_mode = 2; rdy_dly = 2; sdram_dout = 8'h5A;
    cpu_we = 1'b0; cpu_addr = 25'h0004000; cpu_req = 1'b1;
    k = cyc;
    push_stb(1'b0, 25'h0004000, 8'h00, k + 1);
    push_ack(1, 1'b1, 8'h5A, k + 4);
    @(negedge clk);
    chk("busy_rise", {31'd0, busy}, 32'd1);
    run(0, 1, 0);
    @(negedge clk);
    chk("busy_fall", {31'd0, busy}, 32'd0);
    sdram_dout = 8'h00;
    repeat (3) @(negedge clk);
    chk("cpu_dout_held", {24'd0, cpu_dout}, 32'h5A);

    // Simultaneous requests: dw, then cpu, then bk
    rdy_mode = 0; sdram_dout = 8'h77;
    dw_addr = 25'h1FFFFFF; dw_din = 8'h11;
    cpu_we = 1'b0; cpu_addr = 25'h0000123;
    bk_we = 1'b1; bk_addr = 25'h1000000; bk_din = 8'h22;
    dw_req = 1'b1; cpu_req = 1'b1; bk_req = 1'b1;
    k = cyc;
    push_stb(1'b1, 25'h1FFFFFF, 8'h11, k + 1);
    push_ack(0, 1'b0, 8'h00, k + 3);
    push_stb(1'b0, 25'h0000123, 8'h00, k + 5);
    push_ack(1, 1'b1, 8'h77, k + 7);
    push_stb(1'b1, 25'h1000000, 8'h22, k + 9);
    push_ack(2, 1'b0, 8'h00, k + 11);
    run(1, 1, 1);
    repeat (2) @(negedge clk);
    chk("addr_hold", {7'd0, sdram_addr}, 32'h1000000);
    chk("din_hold", {24'd0, sdram_din}, 32'h22);

    // Starvation guard: 8 CPU grants, then bk, then CPU again
    cpu_we = 1'b1; cpu_addr = 25'h0000200; cpu_din = 8'h33;
    bk_we = 1'b1; bk_addr = 25'h0000300; bk_din = 8'h44;
    cpu_req = 1'b1; bk_req = 1'b1;
    k = cyc;
    for (int i = 0; i < 8; i++) begin
      push_stb(1'b1, 25'h0000200, 8'h33, k + 1 + 4 * i);
      push_ack(1, 1'b0, 8'h00, k + 3 + 4 * i);
    end
    push_stb(1'b1, 25'h0000300, 8'h44, k + 33);
    push_ack(2, 1'b0, 8'h00, k + 35);
    push_stb(1'b1, 25'h0000200, 8'h33, k + 37);
    push_ack(1, 1'b0, 8'h00, k + 39);
    run(0, 9, 1);
    repeat (2) @(negedge clk);

    // CPU write abort: ack 256 cycles after the strobe
    chk("terr_before_abort", {31'd0, timeout_err}, 32'd0);
    rdy_mode = 1;
    cpu_we = 1'b1; cpu_addr = 25'h0000400; cpu_din = 8'hC3; cpu_req = 1'b1;
    k = cyc;
    push_stb(1'b1, 25'h0000400, 8'hC3, k + 1);
    push_ack(1, 1'b0, 8'h00, k + 257);
    run(0, 1, 0);
    @(negedge clk);
    chk("terr_after_abort", {31'd0, timeout_err}, 32'd1);

    // Good read afterwards: error stays sticky
    rdy_mode = 0; sdram_dout = 8'h96;
    cpu_we = 1'b0; cpu_addr = 25'h0000500; cpu_req = 1'b1;
    k = cyc;
    push_stb(1'b0, 25'h0000500, 8'h00, k + 1);
    push_ack(1, 1'b1, 8'h96, k + 3);
    run(0, 1, 0);
    @(negedge clk);
    chk("terr_sticky", {31'd0, timeout_err}, 32'd1);

    // CPU read abort returns FF
    rdy_mode = 1; sdram_dout = 8'h5A;
    cpu_we = 1'b0; cpu_addr = 25'h0000600; cpu_req = 1'b1;
    k = cyc;
    push_stb(1'b0, 25'h0000600, 8'h00, k + 1);
    push_ack(1, 1'b1, 8'hFF, k + 257);
    run(0, 1, 0);
    @(negedge clk);
    chk("rd_abort_dout", {24'd0, cpu_dout}, 32'hFF);
    chk("rd_abort_terr", {31'd0, timeout_err}, 32'd1);

    // Reset during WAIT of a bk read, with a CPU request pending
    bk_we = 1'b0; bk_addr = 25'h0000700; bk_req = 1'b1;
    k = cyc;
    push_stb(1'b0, 25'h0000700, 8'h00, k + 1);
    repeat (4) @(negedge clk);
    chk("busy_in_wait", {31'd0, busy}, 32'd1);
    cpu_we = 1'b0; cpu_addr = 25'h0000800; cpu_req = 1'b1;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    bk_req = 1'b0;
    @(negedge clk);
    rdy_mode = 0; sdram_dout = 8'h3C;
    reset_n = 1'b1;
    k = cyc;
    push_stb(1'b0, 25'h0000800, 8'h00, k + 1);
    push_ack(1, 1'b1, 8'h3C, k + 3);
    run(0, 1, 0);
    repeat (6) @(negedge clk);
    chk("ack_queue_empty", aq.size(), 32'd0);
    chk("stb_queue_empty", sq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
